// File: rtl/pkt_buf_pkg.sv
// Shared widths, port-count default and allocator FSM encoding for the packet-buffer ID path.
// Imported by the allocator and the bufid return path so both agree on ID and count widths.
package pkt_buf_pkg;
   localparam int NUM_PORT_DFLT = 9;
   localparam int BUFID_W       = 9;
   localparam int OUTNUM_W      = 4;
   localparam int STAT_W        = 16;

   typedef enum logic [1:0] {
      IDLE_S  = 2'd0,
      RD_S    = 2'd1,
      WAIT_S  = 2'd2,
      GRANT_S = 2'd3
   } alloc_state_t;
endpackage

// File: rtl/pkt_bufid_alloc_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping, zero latency.
// No backpressure; the parent decides when to register and consume the result.
module rr_arbiter #(
   parameter int N     = 9,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);
   logic found;
   int   p;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      p     = 0;
      for (int i = 0; i < N; i++) begin
         p = int'(ptr) + i;
         if (p >= N) p = p - N;
         if (!found && req[p]) begin
            found    = 1'b1;
            grant[p] = 1'b1;
            idx      = IDX_W'(p);
         end
      end
   end

   assign any = |req;
endmodule

// File: rtl/pkt_bufid_alloc.sv
// Pops free buffer IDs and grants one per request, round-robin; seeds the per-ID outport count.
// Request-to-ack latency 3 cycles, one grant per 4; stalls in IDLE_S while the free FIFO is empty.
// Optional grant/stall statistics counters are built only with PKT_BUFID_ALLOC_STAT_EN defined.
module pkt_bufid_alloc
   import pkt_buf_pkg::*;
#(
   parameter int NUM_PORT = NUM_PORT_DFLT,
   parameter int BUFID_W  = pkt_buf_pkg::BUFID_W,
   parameter int OUTNUM_W = pkt_buf_pkg::OUTNUM_W
) (
   input  logic                         clk_sys,
   input  logic                         reset,
   input  logic [NUM_PORT-1:0]          iv_bufid_req,
   input  logic [NUM_PORT*OUTNUM_W-1:0] iv_outport_num,
   output logic [NUM_PORT-1:0]          ov_bufid_ack,
   output logic [BUFID_W-1:0]           ov_bufid,
   output logic                         o_pkt_bufid_rd,
   input  logic [BUFID_W-1:0]           iv_pkt_bufid,
   input  logic                         i_pkt_bufid_empty,
   output logic                         o_cnt_wr,
   output logic [BUFID_W-1:0]           ov_cnt_addr,
   output logic [OUTNUM_W-1:0]          ov_cnt_data,
   output logic [1:0]                   ov_alloc_state,
   output logic [STAT_W-1:0]            ov_alloc_cnt,
   output logic [STAT_W-1:0]            ov_empty_stall_cnt
);
   localparam int IDX_W = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;

   alloc_state_t          state, state_d;
   logic [IDX_W-1:0]      rr_ptr, rr_ptr_d;
   logic [IDX_W-1:0]      port_q, port_d;
   logic [NUM_PORT-1:0]   grant_q, grant_d;
   logic [OUTNUM_W-1:0]   outnum_q, outnum_d;
   logic [NUM_PORT-1:0]   ack_q, ack_d;
   logic [BUFID_W-1:0]    bufid_q, bufid_d;
   logic                  rd_q, rd_d;
   logic                  cnt_wr_q, cnt_wr_d;
   logic [OUTNUM_W-1:0]   cnt_data_q, cnt_data_d;

   logic [NUM_PORT-1:0]   arb_grant;
   logic [IDX_W-1:0]      arb_idx;
   logic                  arb_any;
   logic                  dead;

   rr_arbiter #(.N(NUM_PORT), .IDX_W(IDX_W)) u_arb (
      .req   (iv_bufid_req),
      .ptr   (rr_ptr),
      .grant (arb_grant),
      .idx   (arb_idx),
      .any   (arb_any)
   );

   // A requester still sees its own ack this cycle; never grant it a second time.
   assign dead = |ack_q;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= IDLE_S;
         rr_ptr     <= '0;
         port_q     <= '0;
         grant_q    <= '0;
         outnum_q   <= '0;
         ack_q      <= '0;
         bufid_q    <= '0;
         rd_q       <= 1'b0;
         cnt_wr_q   <= 1'b0;
         cnt_data_q <= '0;
      end else begin
         state      <= state_d;
         rr_ptr     <= rr_ptr_d;
         port_q     <= port_d;
         grant_q    <= grant_d;
         outnum_q   <= outnum_d;
         ack_q      <= ack_d;
         bufid_q    <= bufid_d;
         rd_q       <= rd_d;
         cnt_wr_q   <= cnt_wr_d;
         cnt_data_q <= cnt_data_d;
      end
   end

   // Outputs are registered, so each state's outputs are loaded on the edge that enters it.
   always_comb begin
      state_d    = state;
      rr_ptr_d   = rr_ptr;
      port_d     = port_q;
      grant_d    = grant_q;
      outnum_d   = outnum_q;
      ack_d      = '0;
      bufid_d    = bufid_q;
      rd_d       = 1'b0;
      cnt_wr_d   = 1'b0;
      cnt_data_d = cnt_data_q;
      case (state)
         IDLE_S: begin
            if (!dead && arb_any && !i_pkt_bufid_empty) begin
               port_d   = arb_idx;
               grant_d  = arb_grant;
               outnum_d = iv_outport_num[int'(arb_idx)*OUTNUM_W +: OUTNUM_W];
               rd_d     = 1'b1;
               state_d  = RD_S;
            end
         end
         RD_S: begin
            state_d = WAIT_S;
         end
         WAIT_S: begin
            bufid_d    = iv_pkt_bufid;
            cnt_data_d = (outnum_q == '0) ? OUTNUM_W'(1) : outnum_q;
            ack_d      = grant_q;
            cnt_wr_d   = 1'b1;
            rr_ptr_d   = (port_q == IDX_W'(NUM_PORT-1)) ? '0 : port_q + 1'b1;
            state_d    = GRANT_S;
         end
         GRANT_S: begin
            state_d = IDLE_S;
         end
         default: begin
            state_d = IDLE_S;
         end
      endcase
   end

   assign ov_bufid_ack   = ack_q;
   assign ov_bufid       = bufid_q;
   assign ov_cnt_addr    = bufid_q;
   assign o_pkt_bufid_rd = rd_q;
   assign o_cnt_wr       = cnt_wr_q;
   assign ov_cnt_data    = cnt_data_q;
   assign ov_alloc_state = state;

`ifdef PKT_BUFID_ALLOC_STAT_EN
   logic [STAT_W-1:0] alloc_cnt;
   logic [STAT_W-1:0] stall_cnt;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         alloc_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (dead && alloc_cnt != '1)
            alloc_cnt <= alloc_cnt + 1'b1;
         if (state == IDLE_S && !dead && arb_any && i_pkt_bufid_empty && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign ov_alloc_cnt       = alloc_cnt;
   assign ov_empty_stall_cnt = stall_cnt;
`else
   assign ov_alloc_cnt       = '0;
   assign ov_empty_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_pkt_bufid_alloc.sv
// Directed bench for pkt_bufid_alloc with a free-FIFO model and a grant scoreboard.
module tb_pkt_bufid_alloc;
   localparam int NP = 9;
   localparam int BW = 9;
   localparam int OW = 4;
`ifdef PKT_BUFID_ALLOC_STAT_EN
   localparam int STALL_EXP = 10;
   localparam int ALLOC_EXP = 8;
`else
   localparam int STALL_EXP = 0;
   localparam int ALLOC_EXP = 0;
`endif

   logic              clk_sys = 1'b0;
   logic              reset;
   logic [NP-1:0]     iv_bufid_req;
   logic [NP*OW-1:0]  iv_outport_num;
   logic [NP-1:0]     ov_bufid_ack;
   logic [BW-1:0]     ov_bufid;
   logic              o_pkt_bufid_rd;
   logic [BW-1:0]     iv_pkt_bufid;
   logic              i_pkt_bufid_empty;
   logic              o_cnt_wr;
   logic [BW-1:0]     ov_cnt_addr;
   logic [OW-1:0]     ov_cnt_data;
   logic [1:0]        ov_alloc_state;
   logic [15:0]       ov_alloc_cnt;
   logic [15:0]       ov_empty_stall_cnt;

   always #5 clk_sys = ~clk_sys;

   pkt_bufid_alloc dut (
      .clk_sys            (clk_sys),
      .reset              (reset),
      .iv_bufid_req       (iv_bufid_req),
      .iv_outport_num     (iv_outport_num),
      .ov_bufid_ack       (ov_bufid_ack),
      .ov_bufid           (ov_bufid),
      .o_pkt_bufid_rd     (o_pkt_bufid_rd),
      .iv_pkt_bufid       (iv_pkt_bufid),
      .i_pkt_bufid_empty  (i_pkt_bufid_empty),
      .o_cnt_wr           (o_cnt_wr),
      .ov_cnt_addr        (ov_cnt_addr),
      .ov_cnt_data        (ov_cnt_data),
      .ov_alloc_state     (ov_alloc_state),
      .ov_alloc_cnt       (ov_alloc_cnt),
      .ov_empty_stall_cnt (ov_empty_stall_cnt)
   );

   typedef struct {
      int          port;
      logic [8:0]  id;
      logic [3:0]  cnt;
   } exp_t;

   exp_t       sb[$];
   exp_t       e;
   logic [8:0] fifo_q[$];
   int         total = 0;
   int         bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic upd_empty();
      i_pkt_bufid_empty = (fifo_q.size() == 0);
   endtask

   task automatic fifo_push(input logic [8:0] id);
      fifo_q.push_back(id);
      upd_empty();
   endtask

   task automatic expect_grant(input int port, input logic [8:0] id, input logic [3:0] cnt);
      exp_t x;
      x.port = port;
      x.id   = id;
      x.cnt  = cnt;
      sb.push_back(x);
   endtask

   task automatic set_req(input int port, input int num);
      iv_outport_num[port*OW +: OW] = OW'(num);
      iv_bufid_req[port] = 1'b1;
   endtask

   // One clock: FIFO model answers a strobe seen last cycle, requesters drop on ack.
   task automatic tick();
      logic rd_was;
      rd_was = o_pkt_bufid_rd;
      @(posedge clk_sys);
      #1;
      if (rd_was === 1'b1 && fifo_q.size() > 0) iv_pkt_bufid = fifo_q.pop_front();
      iv_bufid_req = iv_bufid_req & ~ov_bufid_ack;
      upd_empty();
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ack"},   32'(ov_bufid_ack), 0);
      chk({tag, "_bufid"}, 32'(ov_bufid), 0);
      chk({tag, "_rd"},    32'(o_pkt_bufid_rd), 0);
      chk({tag, "_wr"},    32'(o_cnt_wr), 0);
      chk({tag, "_addr"},  32'(ov_cnt_addr), 0);
      chk({tag, "_data"},  32'(ov_cnt_data), 0);
      chk({tag, "_state"}, 32'(ov_alloc_state), 0);
      chk({tag, "_alloc"}, 32'(ov_alloc_cnt), 0);
      chk({tag, "_stall"}, 32'(ov_empty_stall_cnt), 0);
   endtask

   // Scoreboard monitor: every grant cycle must match the next queued expectation.
   always @(negedge clk_sys) begin
      if (reset === 1'b0 && (ov_bufid_ack !== '0 || o_cnt_wr !== 1'b0)) begin
         if (sb.size() == 0) begin
            chk("unexpected_grant", {22'd0, ov_bufid_ack, o_cnt_wr}, 0);
         end else begin
            e = sb.pop_front();
            chk("mon_ack",  32'(ov_bufid_ack), 32'(1) << e.port);
            chk("mon_id",   32'(ov_bufid), 32'(e.id));
            chk("mon_wr",   32'(o_cnt_wr), 1);
            chk("mon_addr", 32'(ov_cnt_addr), 32'(e.id));
            chk("mon_data", 32'(ov_cnt_data), 32'(e.cnt));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      iv_bufid_req   = '1;
      iv_outport_num = '1;
      iv_pkt_bufid   = '0;
      upd_empty();

      // Reset held with every port requesting.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_rd", 32'(o_pkt_bufid_rd), 0);
      end
      chk_idle_outputs("rst");
      iv_bufid_req   = '0;
      iv_outport_num = '0;
      reset          = 1'b0;
      tick();

      // Ports 0, 4, 8 together from rr_ptr 0.
      fifo_push(9'h010); fifo_push(9'h011); fifo_push(9'h012);
      expect_grant(0, 9'h010, 4'd1);
      expect_grant(4, 9'h011, 4'd3);
      expect_grant(8, 9'h012, 4'd7);
      set_req(0, 1); set_req(4, 3); set_req(8, 7);
      for (int i = 1; i <= 12; i++) begin
         logic [NP-1:0] exp_ack;
         tick();
         exp_ack = (i == 3) ? NP'(1) : (i == 7) ? NP'(1) << 4 : (i == 11) ? NP'(1) << 8 : '0;
         chk("arb_ack", 32'(ov_bufid_ack), 32'(exp_ack));
      end

      // Single request on port 3: rd at N+1, ack at N+3.
      fifo_push(9'h0A5);
      expect_grant(3, 9'h0A5, 4'd2);
      set_req(3, 2);
      tick();
      chk("single_rd1", 32'(o_pkt_bufid_rd), 1);
      chk("single_st1", 32'(ov_alloc_state), 1);
      tick();
      chk("single_rd2", 32'(o_pkt_bufid_rd), 0);
      chk("single_st2", 32'(ov_alloc_state), 2);
      tick();
      chk("single_ack", 32'(ov_bufid_ack), 32'(1) << 3);
      chk("single_st3", 32'(ov_alloc_state), 3);
      tick();
      chk("single_noack", 32'(ov_bufid_ack), 0);

      // rr_ptr is now 4: port 4 wins over port 2, then wrap back to 2.
      fifo_push(9'h020); fifo_push(9'h021);
      expect_grant(4, 9'h020, 4'd15);
      expect_grant(2, 9'h021, 4'd5);
      set_req(2, 5); set_req(4, 15);
      for (int i = 1; i <= 8; i++) begin
         logic [NP-1:0] exp_ack;
         tick();
         exp_ack = (i == 3) ? NP'(1) << 4 : (i == 7) ? NP'(1) << 2 : '0;
         chk("rr_ack", 32'(ov_bufid_ack), 32'(exp_ack));
      end

      // Port 1 against an empty FIFO for 10 cycles.
      set_req(1, 3);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("stall_rd", 32'(o_pkt_bufid_rd), 0);
      end
      chk("stall_cnt", 32'(ov_empty_stall_cnt), STALL_EXP);
      fifo_push(9'h1F0);
      expect_grant(1, 9'h1F0, 4'd3);
      tick();
      chk("stall_rd_go", 32'(o_pkt_bufid_rd), 1);
      tick();
      tick();
      chk("stall_ack", 32'(ov_bufid_ack), 32'(1) << 1);
      tick();
      chk("stall_cnt_hold", 32'(ov_empty_stall_cnt), STALL_EXP);

      // outport_num 0 is written as 1.
      fifo_push(9'h0C6);
      expect_grant(6, 9'h0C6, 4'd1);
      set_req(6, 0);
      repeat (3) tick();
      chk("clamp_data", 32'(ov_cnt_data), 1);
      tick();
      chk("alloc_cnt", 32'(ov_alloc_cnt), ALLOC_EXP);

      // Reset while in WAIT_S: the popped ID is dropped, no grant follows.
      fifo_push(9'h1AB);
      set_req(5, 9);
      tick();
      tick();
      chk("wrst_state", 32'(ov_alloc_state), 2);
      reset = 1'b1;
      tick();
      chk_idle_outputs("wrst");
      iv_bufid_req = '0;
      reset        = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("wrst_noack", {22'd0, ov_bufid_ack, o_cnt_wr}, 0);
      end

      chk("sb_drained", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pkt_bufid_alloc.md
# pkt_bufid_alloc

- Allocates free packet-buffer IDs to receive-port write engines.
- Pops the central free-bufid FIFO, grants one ID per request using round-robin arbitration, and initialises the per-bufid outport reference count in the bufid-count RAM.
- Pairs with the bufid return path, which decrements that count and pushes IDs back into the same FIFO.

## Interface
- NUM_PORT, 9, number of requesting receive ports
- BUFID_W, 9, buffer ID width (512 buffers)
- OUTNUM_W, 4, outport-count width
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- iv_bufid_req  in  NUM_PORT  per-port allocation request, level, held until ack
- iv_outport_num  in  NUM_PORT*OUTNUM_W  per-port destination count, port p at bits [p*OUTNUM_W +: OUTNUM_W], valid while req high
- ov_bufid_ack  out  NUM_PORT  one-hot, one-cycle grant pulse
- ov_bufid  out  BUFID_W  allocated ID, valid in the ack cycle
- o_pkt_bufid_rd  out  1  free-FIFO read strobe
- iv_pkt_bufid  in  BUFID_W  free-FIFO read data, valid one cycle after the strobe
- i_pkt_bufid_empty  in  1  free-FIFO empty
- o_cnt_wr  out  1  count-RAM write enable
- ov_cnt_addr  out  BUFID_W  count-RAM address
- ov_cnt_data  out  OUTNUM_W  initial reference count
- ov_alloc_state  out  2  FSM state, for debug
- ov_alloc_cnt  out  16  number of grants (see Configuration)
- ov_empty_stall_cnt  out  16  cycles with a pending request and an empty FIFO (see Configuration)

## Operation
- States:
  - IDLE_S = 0
  - RD_S = 1
  - WAIT_S = 2
  - GRANT_S = 3
- Round-robin pointer rr_ptr ranges 0..NUM_PORT-1 and resets to 0.
- IDLE_S:
  - Clears ov_bufid_ack and o_cnt_wr.
  - Ignores all requests in any cycle where ov_bufid_ack is high (dead cycle), so a held request is never granted twice.
  - Otherwise, if any request is set and i_pkt_bufid_empty==0:
    - Selects the first requesting port at or after rr_ptr, with wrap-around.
    - Latches that port index and its outport_num.
    - Moves to RD_S.
- RD_S: asserts o_pkt_bufid_rd for exactly one cycle, then moves to WAIT_S.
- WAIT_S: the FIFO presents data. Moves to GRANT_S.
- GRANT_S:
  - Captures iv_pkt_bufid into ov_bufid and ov_cnt_addr.
  - Sets ov_cnt_data to the latched outport_num. A value of 0 is clamped to 1.
  - Asserts o_cnt_wr and ov_bufid_ack[port] for exactly one cycle.
  - Sets rr_ptr to port+1, wrapping NUM_PORT-1 to 0.
  - Returns to IDLE_S.
- The count RAM is written on every grant, unicast included.
- A request withdrawn before its ack is protocol misuse. The grant still completes and the ID is handed out.
- Empty FIFO: no read strobe is issued; the FSM stays in IDLE_S and re-evaluates every cycle.
- Empty is sampled only in IDLE_S. This block is the sole reader of the FIFO, so a non-empty decision stays valid through RD_S.

## Timing
- Reset values (all outputs): ack 0, ov_bufid 0, o_pkt_bufid_rd 0, o_cnt_wr 0, ov_cnt_addr 0, ov_cnt_data 0, state IDLE_S, counters 0, rr_ptr 0.
- Latency: request sampled in IDLE_S at cycle N → rd high in N+1 → ack, bufid and count write high in N+3.
- Requester deasserts or changes its request from cycle N+4 onward.
- Maximum throughput: one grant per 4 cycles.
- Reset mid-operation: all outputs return to reset values on the next edge.
  - An ID popped but not yet granted is lost.
  - This is accepted, because system reset re-initialises the free list.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- PKT_BUFID_ALLOC_STAT_EN:
  - Defined: ov_alloc_cnt increments on every ack cycle and saturates at 0xFFFF.
  - Defined: ov_empty_stall_cnt increments in every IDLE_S cycle with a non-dead request pending and empty==1, and saturates at 0xFFFF.
  - Undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- Shared package pkt_buf_pkg:
  - Widths BUFID_W and OUTNUM_W.
  - State encodings IDLE_S, RD_S, WAIT_S, GRANT_S.
  - NUM_PORT default.
- Sub-module rr_arbiter:
  - Inputs: request vector and rr_ptr.
  - Outputs: one-hot grant vector, encoded index, and any-request flag.
  - Purely combinational; the parent registers its result.

## Test plan
- Reset: assert reset for 3 cycles with requests active → all outputs 0, state 0, no rd strobe.
- Single request: port 3 requests with outport_num=2, FIFO head 0x0A5 → rd in cycle N+1; in N+3 ack[3]=1, ov_bufid=0x0A5, cnt write addr 0x0A5 data 2; rr_ptr=4.
- Arbitration: ports 0, 4 and 8 request together with rr_ptr=0, FIFO holds 0x010, 0x011, 0x012 → grants go to 0, 4, 8 in order with IDs 0x010, 0x011, 0x012 respectively, spaced 4 cycles apart; there is no double grant to port 0.
- Empty stall: port 1 requests while empty=1 for 10 cycles → no rd and no ack, and the stall count reaches 10 when the macro is defined. Empty then drops → ack[1] arrives 3 cycles after the first non-empty IDLE_S sample.
- Count clamp: port 6 requests with outport_num=0 → ov_cnt_data=1.
- Reset in WAIT_S: reset is asserted in WAIT_S → no ack and no count write follow; outputs are 0 and the FSM is in IDLE_S after the edge.
